// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for the MCU's 8-bit ALU: accepts one command at a time,
// reads operands from an internal 8x8 register file, captures the ALU result and flags, and writes the result back.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command; illegal opcodes pulse err
// READ  | operands fetched from the register file into the ALU input flops
// EXEC  | ALU inputs held stable; result and flags captured
// WRITE | result written to rd (discarded for r0), done pulses
module alu_op_sequencer #(
   parameter int         NREGS  = 8,
   parameter logic [3:0] MAX_OP = 4'd9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [2:0] cmd_rd,
   input  logic [2:0] cmd_rs,
   input  logic [2:0] cmd_rt,
   input  logic [7:0] cmd_imm,
   input  logic       cmd_use_imm,
   input  logic [2:0] cmd_shamt,
   output logic [3:0] alu_fsel,
   output logic [2:0] alu_shift,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_f,
   input  logic       alu_zero,
   input  logic       alu_neg,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   output logic       done,
   output logic       err,
   output logic [7:0] result,
   output logic [3:0] flags,
   input  logic [2:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] regs_q [NREGS];
   logic [7:0] regs_d [NREGS];

   logic [3:0] op_q, op_d;
   logic [2:0] rd_q, rd_d;
   logic [2:0] rs_q, rs_d;
   logic [2:0] rt_q, rt_d;
   logic [7:0] imm_q, imm_d;
   logic       use_imm_q, use_imm_d;
   logic [2:0] shamt_q, shamt_d;

   logic       cmd_ready_q, cmd_ready_d;
   logic [3:0] alu_fsel_q, alu_fsel_d;
   logic [2:0] alu_shift_q, alu_shift_d;
   logic [7:0] alu_a_q, alu_a_d;
   logic [7:0] alu_b_q, alu_b_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] result_q, result_d;
   logic [3:0] flags_q, flags_d;

   always_comb begin
      state_d     = state_q;
      regs_d      = regs_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      imm_d       = imm_q;
      use_imm_d   = use_imm_q;
      shamt_d     = shamt_q;
      cmd_ready_d = cmd_ready_q;
      alu_fsel_d  = alu_fsel_q;
      alu_shift_d = alu_shift_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      result_d    = result_q;
      flags_d     = flags_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d      = cmd_op;
               rd_d      = cmd_rd;
               rs_d      = cmd_rs;
               rt_d      = cmd_rt;
               imm_d     = cmd_imm;
               use_imm_d = cmd_use_imm;
               shamt_d   = cmd_shamt;
               if (cmd_op > MAX_OP) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = READ;
                  cmd_ready_d = 1'b0;
               end
            end
         end
         READ: begin
            // r0 is never written, so indexing it always yields zero
            alu_a_d     = regs_q[rs_q];
            alu_b_d     = use_imm_q ? imm_q : regs_q[rt_q];
            alu_fsel_d  = op_q;
            alu_shift_d = shamt_q;
            state_d     = EXEC;
         end
         EXEC: begin
            result_d = alu_f;
            flags_d  = {alu_zero, alu_neg, alu_carry, alu_overflow};
            done_d   = 1'b1;
            state_d  = WRITE;
         end
         WRITE: begin
            if (rd_q != 3'd0) regs_d[rd_q] = result_q;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
         op_q        <= 4'd0;
         rd_q        <= 3'd0;
         rs_q        <= 3'd0;
         rt_q        <= 3'd0;
         imm_q       <= 8'd0;
         use_imm_q   <= 1'b0;
         shamt_q     <= 3'd0;
         cmd_ready_q <= 1'b1;
         alu_fsel_q  <= 4'd0;
         alu_shift_q <= 3'd0;
         alu_a_q     <= 8'd0;
         alu_b_q     <= 8'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         result_q    <= 8'd0;
         flags_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         regs_q      <= regs_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
         shamt_q     <= shamt_d;
         cmd_ready_q <= cmd_ready_d;
         alu_fsel_q  <= alu_fsel_d;
         alu_shift_q <= alu_shift_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         done_q      <= done_d;
         err_q       <= err_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign alu_fsel  = alu_fsel_q;
   assign alu_shift = alu_shift_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; a behavioural ALU closes the loop on the ALU ports.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [2:0] cmd_rd, cmd_rs, cmd_rt;
   logic [7:0] cmd_imm;
   logic       cmd_use_imm;
   logic [2:0] cmd_shamt;
   logic [3:0] alu_fsel;
   logic [2:0] alu_shift;
   logic [7:0] alu_a, alu_b, alu_f;
   logic       alu_zero, alu_neg, alu_carry, alu_overflow;
   logic       done, err;
   logic [7:0] result;
   logic [3:0] flags;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;

   int checks = 0;
   int errors = 0;

   logic [3:0] v_done, v_ready, v_err;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
      .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm), .cmd_shamt(cmd_shamt),
      .alu_fsel(alu_fsel), .alu_shift(alu_shift), .alu_a(alu_a), .alu_b(alu_b),
      .alu_f(alu_f), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .done(done), .err(err), .result(result), .flags(flags),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Behavioural ALU: carry is the add carry-out / sub borrow, zero for logic ops.
   logic [8:0] m_w;
   always_comb begin
      m_w          = 9'd0;
      alu_f        = 8'd0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (alu_fsel)
         4'd0: begin
            m_w          = {1'b0, alu_a} + {1'b0, alu_b};
            alu_f        = m_w[7:0];
            alu_carry    = m_w[8];
            alu_overflow = (alu_a[7] == alu_b[7]) && (m_w[7] != alu_a[7]);
         end
         4'd1: alu_f = alu_a & alu_b;
         4'd2: begin
            m_w          = {1'b0, alu_a} - {1'b0, alu_b};
            alu_f        = m_w[7:0];
            alu_carry    = m_w[8];
            alu_overflow = (alu_a[7] != alu_b[7]) && (m_w[7] != alu_a[7]);
         end
         4'd3: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
         4'd4: alu_f = ~alu_a;
         4'd5: alu_f = alu_a | alu_b;
         4'd6: alu_f = alu_a ^ alu_b;
         4'd7: alu_f = alu_a << alu_shift;
         4'd8: alu_f = alu_a >> alu_shift;
         4'd9: alu_f = 8'd1;
         default: alu_f = 8'd0;
      endcase
      alu_zero = (alu_f == 8'd0);
      alu_neg  = alu_f[7];
   end

   // Drives one command and records done/ready/err for the four cycles after the
   // accepting edge; bit i corresponds to cycle T+1+i.
   task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [7:0] imm, input logic use_imm,
                          input logic [2:0] shamt);
      @(negedge clk);
      cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
      cmd_imm = imm; cmd_use_imm = use_imm; cmd_shamt = shamt;
      cmd_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) cmd_valid = 1'b0;
         v_done[i]  = done;
         v_ready[i] = cmd_ready;
         v_err[i]   = err;
      end
   endtask

   task automatic read_dbg(input logic [2:0] addr, output logic [7:0] val);
      dbg_addr = addr;
      #1;
      val = dbg_data;
   endtask

   task automatic test_reset;
      logic [7:0] v;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
      checks++;
      if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got done/err %b want 00", {done, err}); end
      checks++;
      if ({result, flags} !== 12'h000) begin errors++; $display("FAIL reset_result: got %h/%b want 00/0000", result, flags); end
      checks++;
      if ({alu_fsel, alu_shift, alu_a, alu_b} !== 23'd0) begin
         errors++; $display("FAIL reset_alu_in: got fsel=%h sh=%h a=%h b=%h want all 0", alu_fsel, alu_shift, alu_a, alu_b);
      end
      for (int r = 0; r < 8; r++) begin
         read_dbg(3'(r), v);
         checks++;
         if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", r, v); end
      end
   endtask

   task automatic test_add;
      logic [7:0] v;
      run_cmd(4'd0, 3'd1, 3'd0, 3'd0, 8'h7F, 1'b1, 3'd0);
      checks++;
      if (v_ready !== 4'b1000) begin errors++; $display("FAIL add1_ready_timing: got %b want 1000", v_ready); end
      checks++;
      if (v_done !== 4'b0100) begin errors++; $display("FAIL add1_done_timing: got %b want 0100", v_done); end
      checks++;
      if (v_err !== 4'b0000) begin errors++; $display("FAIL add1_err: got %b want 0000", v_err); end
      read_dbg(3'd1, v);
      checks++;
      if (v !== 8'h7F) begin errors++; $display("FAIL add1_r1: got %h want 7f", v); end
      checks++;
      if (flags !== 4'b0000) begin errors++; $display("FAIL add1_flags: got %b want 0000", flags); end

      run_cmd(4'd0, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1, 3'd0);
      read_dbg(3'd2, v);
      checks++;
      if (v !== 8'h80) begin errors++; $display("FAIL add2_r2: got %h want 80", v); end
      checks++;
      if (flags !== 4'b0101) begin errors++; $display("FAIL add2_flags: got %b want 0101", flags); end
      checks++;
      if (result !== 8'h80) begin errors++; $display("FAIL add2_result: got %h want 80", result); end
   endtask

   task automatic test_sub_shift;
      logic [7:0] v;
      run_cmd(4'd2, 3'd3, 3'd2, 3'd2, 8'h55, 1'b0, 3'd0);
      read_dbg(3'd3, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL sub_r3: got %h want 00", v); end
      checks++;
      if (flags !== 4'b1000) begin errors++; $display("FAIL sub_flags: got %b want 1000", flags); end

      run_cmd(4'd7, 3'd4, 3'd1, 3'd0, 8'h00, 1'b1, 3'd1);
      read_dbg(3'd4, v);
      checks++;
      if (v !== 8'hFE) begin errors++; $display("FAIL shl_r4: got %h want fe", v); end
      checks++;
      if (flags !== 4'b0100) begin errors++; $display("FAIL shl_flags: got %b want 0100", flags); end
      checks++;
      if ({alu_fsel, alu_shift} !== {4'd7, 3'd1}) begin
         errors++; $display("FAIL shl_alu_hold: got fsel=%h sh=%h want 7/1", alu_fsel, alu_shift);
      end
   endtask

   task automatic test_illegal_op;
      logic [7:0] v;
      logic [7:0] exp_regs [8];
      exp_regs = '{8'h00, 8'h7F, 8'h80, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00};
      run_cmd(4'hA, 3'd5, 3'd1, 3'd2, 8'h33, 1'b1, 3'd2);
      checks++;
      if (v_err !== 4'b0001) begin errors++; $display("FAIL illegal_err: got %b want 0001", v_err); end
      checks++;
      if (v_done !== 4'b0000) begin errors++; $display("FAIL illegal_done: got %b want 0000", v_done); end
      checks++;
      if (v_ready !== 4'b1111) begin errors++; $display("FAIL illegal_ready: got %b want 1111", v_ready); end
      checks++;
      if ({result, flags} !== {8'hFE, 4'b0100}) begin
         errors++; $display("FAIL illegal_result: got %h/%b want fe/0100", result, flags);
      end
      checks++;
      if (alu_fsel !== 4'd7) begin errors++; $display("FAIL illegal_fsel: got %h want 7", alu_fsel); end
      for (int r = 0; r < 8; r++) begin
         read_dbg(3'(r), v);
         checks++;
         if (v !== exp_regs[r]) begin errors++; $display("FAIL illegal_reg%0d: got %h want %h", r, v, exp_regs[r]); end
      end
   endtask

   task automatic test_r0_compare;
      logic [7:0] v;
      run_cmd(4'd6, 3'd0, 3'd1, 3'd0, 8'h7F, 1'b1, 3'd0);
      checks++;
      if (v_done !== 4'b0100) begin errors++; $display("FAIL xor_r0_done: got %b want 0100", v_done); end
      read_dbg(3'd0, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL xor_r0_reg: got %h want 00", v); end
      checks++;
      if ({result, flags} !== {8'h00, 4'b1000}) begin
         errors++; $display("FAIL xor_r0_result: got %h/%b want 00/1000", result, flags);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] v;
      // r5 = r4 + 2 = 0xFE + 2 wraps to 0 with carry
      run_cmd(4'd0, 3'd5, 3'd4, 3'd0, 8'h02, 1'b1, 3'd0);
      read_dbg(3'd5, v);
      checks++;
      if ({v, flags} !== {8'h00, 4'b1010}) begin errors++; $display("FAIL b2b_add_r5: got %h/%b want 00/1010", v, flags); end
      run_cmd(4'd5, 3'd6, 3'd4, 3'd1, 8'h00, 1'b0, 3'd0);
      read_dbg(3'd6, v);
      checks++;
      if ({v, flags} !== {8'hFF, 4'b0100}) begin errors++; $display("FAIL b2b_or_r6: got %h/%b want ff/0100", v, flags); end
      run_cmd(4'd3, 3'd7, 3'd4, 3'd1, 8'h00, 1'b0, 3'd0);
      read_dbg(3'd7, v);
      checks++;
      if ({v, flags} !== {8'h01, 4'b0000}) begin errors++; $display("FAIL b2b_slt_r7: got %h/%b want 01/0000", v, flags); end
      run_cmd(4'd8, 3'd3, 3'd6, 3'd0, 8'h00, 1'b1, 3'd4);
      read_dbg(3'd3, v);
      checks++;
      if ({v, flags} !== {8'h0F, 4'b0000}) begin errors++; $display("FAIL b2b_shr_r3: got %h/%b want 0f/0000", v, flags); end
   endtask

   task automatic test_reset_mid_op;
      logic [7:0] v;
      logic       saw_done;
      @(negedge clk);
      cmd_op = 4'd0; cmd_rd = 3'd7; cmd_rs = 3'd4; cmd_rt = 3'd0;
      cmd_imm = 8'h01; cmd_use_imm = 1'b1; cmd_shamt = 3'd0;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
      saw_done = done;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         saw_done = saw_done | done | err;
      end
      checks++;
      if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", saw_done); end
      checks++;
      if ({result, flags} !== 12'h000) begin errors++; $display("FAIL midrst_result: got %h/%b want 00/0000", result, flags); end
      for (int r = 0; r < 8; r++) begin
         read_dbg(3'(r), v);
         checks++;
         if (v !== 8'h00) begin errors++; $display("FAIL midrst_reg%0d: got %h want 00", r, v); end
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_rd = 3'd0; cmd_rs = 3'd0;
      cmd_rt = 3'd0; cmd_imm = 8'd0; cmd_use_imm = 1'b0; cmd_shamt = 3'd0; dbg_addr = 3'd0;
      test_reset();
      test_add();
      test_sub_shift();
      test_illegal_op();
      test_r0_compare();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit ALU datapath for the MCU.
- Accepts one operation command at a time through a valid/ready handshake.
- Reads operands from an internal 8x8 register file, drives the ALU inputs, and captures the ALU result and flags.
- Writes the result back to the destination register and signals completion.

Parameters:
- NREGS, 8, register file depth (register index width is fixed at 3 bits).
- MAX_OP, 4'd9, highest legal ALU function code; larger codes are rejected.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  4  ALU function code (0000 add, 0001 and, 0010 sub, 0011 slt, 0100 not, 0101 or, 0110 xor, 0111 A<<shift, 1000 A>>shift, 1001 const-1)
- cmd_rd  input  3  destination register
- cmd_rs  input  3  operand A register
- cmd_rt  input  3  operand B register
- cmd_imm  input  8  immediate operand B
- cmd_use_imm  input  1  1: B=cmd_imm, 0: B=reg[cmd_rt]
- cmd_shamt  input  3  shift amount
- alu_fsel  output  4  to ALU function_select
- alu_shift  output  3  to ALU shift
- alu_a  output  8  to ALU A
- alu_b  output  8  to ALU B
- alu_f  input  8  ALU result
- alu_zero, alu_neg, alu_carry, alu_overflow  input  1 each  ALU flags
- done  output  1  one-cycle pulse when an operation retires
- err  output  1  one-cycle pulse when a command is rejected
- result  output  8  last retired result
- flags  output  4  {zero,neg,carry,overflow} from last retired op
- dbg_addr  input  3  debug register read address
- dbg_data  output  8  reg[dbg_addr], combinational read

Behaviour:
- All state updates on rising clk; reset is sampled synchronously.
- Reset:
  - state=IDLE; all registers=0.
  - alu_fsel/alu_shift/alu_a/alu_b=0, result=0, flags=0, done=0, err=0.
  - cmd_ready=1 in the first cycle after reset deasserts.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch all cmd_* fields.
  - If cmd_op>MAX_OP: pulse err next cycle, stay IDLE, no register, flag or result change.
  - Otherwise go to READ.
- READ:
  - cmd_ready=0.
  - Register alu_a=reg[rs]; alu_b=use_imm?imm:reg[rt]; alu_fsel=op; alu_shift=shamt.
  - Go to EXEC.
- EXEC:
  - ALU inputs held stable (the ALU is combinational).
  - Sample alu_f into result and the four flag inputs into flags.
  - Go to WRITE.
- WRITE:
  - reg[rd]<=result unless rd==0.
  - done=1 for exactly this cycle.
  - Go to IDLE.
- Latency: handshake accepted at edge T -> READ in T+1, EXEC in T+2, WRITE/done in T+3, cmd_ready high again in T+4.
- Throughput: one op per 4 cycles.
- Register 0:
  - Always reads 0; writes are discarded.
  - flags and result still update when rd==0, which enables compare-only ops.
- ALU inputs retain their last values in IDLE; no toggling between ops.
- Operand read happens in READ, so the previous op's write-back is always visible to the next op.
- dbg_data reflects the register file before the WRITE edge and the new value after it.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold it until the handshake.
- Reset mid-operation (any state):
  - Abort to IDLE, clear the register file; no done or err.
  - The pending result is discarded.
- done and err are never asserted in the same cycle.
- Width rules: all datapath values are 8 bits; flags are taken verbatim from the ALU, with no reinterpretation.

Test Plan:
- Reset, then ADD rd=1 rs=0 imm=0x7F use_imm=1 -> cmd_ready drops at T+1, done at T+3, dbg(1)=0x7F, flags=0000.
- ADD rd=2 rs=1 imm=0x01 use_imm=1 (r1=0x7F) -> r2=0x80, flags: zero=0, neg=1, overflow=1.
- SUB rd=3 rs=2 rt=2 use_imm=0 -> r3=0x00, flags zero=1; then op 0111 rd=4 rs=1 shamt=1 -> r4=0xFE.
- cmd_op=4'hA with valid -> err pulse one cycle, no done, all registers, result and flags unchanged, cmd_ready stays 1.
- XOR rd=0 rs=1 imm=0x7F use_imm=1 -> done pulses, dbg(0)=0x00, result=0x00, flags zero=1.
- Assert reset during EXEC of an ADD -> next cycle IDLE, cmd_ready=1, no done, all registers read 0.
